// File: rtl/alu_tx_scheduler.sv
// Queues ALU result bytes in a small circular FIFO and hands them to the UART
// transmitter one frame at a time using a start/done handshake.
module alu_tx_scheduler #(
  parameter int SIZEDATA   = 8,
  parameter int DEPTH_LOG2 = 2,
  parameter int TIMEOUT    = 100000
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_push,
  input  logic [SIZEDATA-1:0]   i_push_data,
  input  logic                  i_tx_done,
  input  logic                  i_clear_flags,
  output logic                  o_tx_start,
  output logic [SIZEDATA-1:0]   o_tx_data,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_busy,
  output logic                  o_overflow,
  output logic                  o_timeout
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

  state_t                 state, state_next;
  logic [SIZEDATA-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2-1:0]  rd_ptr, wr_ptr;
  logic [DEPTH_LOG2:0]    count;
  logic [TW-1:0]          tmo_cnt;
  logic                   pop, push_ok, tmo_hit;

  // Handshake: o_tx_start is a one-cycle pulse qualifying o_tx_data; the
  // transmitter answers with a one-cycle i_tx_done, honoured only in WAIT.
  assign pop     = (state == IDLE) && (count != '0);
  assign o_full  = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign push_ok = i_push && (!o_full || pop);

  assign o_tx_start = (state == START);
  assign o_busy     = (state != IDLE);
  assign o_empty    = (count == '0);
  assign o_count    = count;

  always_comb begin
    state_next = state;
    tmo_hit    = 1'b0;
    case (state)
      IDLE:  if (pop) state_next = START;
      START: state_next = WAIT;
      WAIT: begin
        if (i_tx_done) begin
          state_next = GAP;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_hit    = 1'b1;
          state_next = GAP;
        end
      end
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state   <= IDLE;
      tmo_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == START) begin
        tmo_cnt <= '0;
      end else if (state == WAIT && !i_tx_done && !tmo_hit) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge i_clock) begin
    if (push_ok) mem[wr_ptr] <= i_push_data;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      o_tx_data <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + DEPTH_LOG2'(1);
        o_tx_data <= mem[rd_ptr];
      end
      if (push_ok && !pop) begin
        count <= count + (DEPTH_LOG2+1)'(1);
      end else if (pop && !push_ok) begin
        count <= count - (DEPTH_LOG2+1)'(1);
      end
    end
  end

  // Sticky flags: a set on the same edge as a clear takes priority.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_overflow <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      if (i_push && !push_ok)  o_overflow <= 1'b1;
      else if (i_clear_flags)  o_overflow <= 1'b0;
      if (tmo_hit)             o_timeout  <= 1'b1;
      else if (i_clear_flags)  o_timeout  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_tx_scheduler.sv
// Directed bench for alu_tx_scheduler: ordering, full/overflow, same-edge
// push/pop, timeout, async reset and stray done pulses.
module tb_alu_tx_scheduler;

  logic       i_clock = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_push = 1'b0;
  logic [7:0] i_push_data = 8'h00;
  logic       i_tx_done = 1'b0;
  logic       i_clear_flags = 1'b0;
  logic       o_tx_start;
  logic [7:0] o_tx_data;
  logic [2:0] o_count;
  logic       o_empty, o_full, o_busy, o_overflow, o_timeout;

  int vectors = 0;
  int miscompares = 0;
  int n_starts = 0;
  logic [7:0] exp_q[$];

  alu_tx_scheduler #(.SIZEDATA(8), .DEPTH_LOG2(2), .TIMEOUT(20)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_push(i_push),
    .i_push_data(i_push_data), .i_tx_done(i_tx_done),
    .i_clear_flags(i_clear_flags), .o_tx_start(o_tx_start),
    .o_tx_data(o_tx_data), .o_count(o_count), .o_empty(o_empty),
    .o_full(o_full), .o_busy(o_busy), .o_overflow(o_overflow),
    .o_timeout(o_timeout)
  );

  always #5 i_clock = ~i_clock;

  // Scoreboard: every start must carry the oldest expected byte.
  always @(negedge i_clock) begin
    if (!i_reset && o_tx_start === 1'b1) begin
      logic [7:0] exp;
      n_starts++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_start: data=%h, required no start", o_tx_data);
      end else begin
        exp = exp_q.pop_front();
        if (o_tx_data !== exp) begin
          miscompares++;
          $display("FAIL tx_data: got %h, required %h", o_tx_data, exp);
        end
      end
    end
  end

  task automatic wait_start(input int bound);
    bit found = 0;
    for (int i = 0; i <= bound && !found; i++) begin
      if (o_tx_start === 1'b1) found = 1;
      else @(negedge i_clock);
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL wait_start: no o_tx_start within %0d cycles", bound);
    end
  endtask

  task automatic pulse_done(input int dly);
    repeat (dly) @(negedge i_clock);
    i_tx_done = 1'b1;
    @(negedge i_clock);
    i_tx_done = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge i_clock);
    vectors++;
    if ({o_tx_start, o_tx_data, o_count, o_empty, o_full, o_busy, o_overflow, o_timeout}
        !== {1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_outputs: start=%b data=%h count=%0d empty=%b full=%b busy=%b ovf=%b tmo=%b, required 0/00/0/1/0/0/0/0",
               o_tx_start, o_tx_data, o_count, o_empty, o_full, o_busy, o_overflow, o_timeout);
    end
    i_reset = 1'b0;
    @(negedge i_clock);
  endtask

  task automatic test_single();
    exp_q.push_back(8'h2A);
    i_push = 1'b1; i_push_data = 8'h2A;
    @(negedge i_clock);
    i_push = 1'b0;
    vectors++;
    if (o_count !== 3'd1 || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_queued: count=%0d busy=%b, required 1/0", o_count, o_busy);
    end
    @(negedge i_clock);
    vectors++;
    if (o_tx_start !== 1'b1 || o_count !== 3'd0 || o_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_start: start=%b count=%0d busy=%b, required 1/0/1", o_tx_start, o_count, o_busy);
    end
    pulse_done(10);
    vectors++;
    if (o_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_gap: busy=%b, required 1", o_busy);
    end
    @(negedge i_clock);
    vectors++;
    if (o_busy !== 1'b0 || n_starts !== 1) begin
      miscompares++;
      $display("FAIL single_idle: busy=%b starts=%0d, required 0/1", o_busy, n_starts);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
    for (int i = 1; i <= 5; i++) begin
      i_push = 1'b1; i_push_data = 8'(i);
      @(negedge i_clock);
    end
    i_push_data = 8'h06;
    @(negedge i_clock);
    i_push = 1'b0;
    vectors++;
    if (o_count !== 3'd4 || o_full !== 1'b1 || o_overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow: count=%0d full=%b ovf=%b, required 4/1/1", o_count, o_full, o_overflow);
    end
    pulse_done(0);
    for (int i = 0; i < 4; i++) begin
      wait_start(20);
      pulse_done(2);
    end
    repeat (2) @(negedge i_clock);
    vectors++;
    if (exp_q.size() != 0 || o_empty !== 1'b1 || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_drain: pending=%0d empty=%b busy=%b, required 0/1/0", exp_q.size(), o_empty, o_busy);
    end
    i_clear_flags = 1'b1;
    @(negedge i_clock);
    i_clear_flags = 1'b0;
    vectors++;
    if (o_overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_clear: ovf=%b, required 0", o_overflow);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 5; i++) exp_q.push_back(8'hA0 + 8'(i));
    exp_q.push_back(8'h77);
    for (int i = 0; i < 5; i++) begin
      i_push = 1'b1; i_push_data = 8'hA0 + 8'(i);
      @(negedge i_clock);
    end
    i_push = 1'b0;
    pulse_done(0);
    @(negedge i_clock);
    vectors++;
    if (o_busy !== 1'b0 || o_count !== 3'd4 || o_full !== 1'b1) begin
      miscompares++;
      $display("FAIL full_idle: busy=%b count=%0d full=%b, required 0/4/1", o_busy, o_count, o_full);
    end
    i_push = 1'b1; i_push_data = 8'h77;
    @(negedge i_clock);
    i_push = 1'b0;
    vectors++;
    if (o_count !== 3'd4 || o_overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL push_pop_full: count=%0d ovf=%b, required 4/0", o_count, o_overflow);
    end
    for (int i = 0; i < 5; i++) begin
      wait_start(20);
      pulse_done(1);
    end
    repeat (2) @(negedge i_clock);
    vectors++;
    if (exp_q.size() != 0 || o_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL full_drain: pending=%0d empty=%b, required 0/1", exp_q.size(), o_empty);
    end
  endtask

  task automatic test_timeout();
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h66);
    i_push = 1'b1; i_push_data = 8'h55;
    @(negedge i_clock);
    i_push_data = 8'h66;
    @(negedge i_clock);
    i_push = 1'b0;
    wait_start(5);
    repeat (20) @(negedge i_clock);
    vectors++;
    if (o_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_early: tmo=%b after 19 WAIT cycles, required 0", o_timeout);
    end
    @(negedge i_clock);
    vectors++;
    if (o_timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_set: tmo=%b after 20 WAIT cycles, required 1", o_timeout);
    end
    repeat (2) @(negedge i_clock);
    vectors++;
    if (o_tx_start !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_next_start: start=%b, required 1", o_tx_start);
    end
    pulse_done(1);
    repeat (2) @(negedge i_clock);
    i_clear_flags = 1'b1;
    @(negedge i_clock);
    i_clear_flags = 1'b0;
    vectors++;
    if (o_timeout !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL timeout_clear: tmo=%b pending=%0d, required 0/0", o_timeout, exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    int starts0;
    exp_q.push_back(8'hB0);
    for (int i = 0; i < 4; i++) begin
      i_push = 1'b1; i_push_data = 8'hB0 + 8'(i);
      @(negedge i_clock);
    end
    i_push = 1'b0;
    vectors++;
    if (o_count !== 3'd3 || o_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset: count=%0d busy=%b, required 3/1", o_count, o_busy);
    end
    @(negedge i_clock);
    #2 i_reset = 1'b1;
    #1;
    vectors++;
    if ({o_tx_start, o_tx_data, o_count, o_empty, o_full, o_busy}
        !== {1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset: start=%b data=%h count=%0d empty=%b full=%b busy=%b, required 0/00/0/1/0/0",
               o_tx_start, o_tx_data, o_count, o_empty, o_full, o_busy);
    end
    @(negedge i_clock);
    i_reset = 1'b0;
    starts0 = n_starts;
    repeat (30) @(negedge i_clock);
    vectors++;
    if (n_starts !== starts0 || o_count !== 3'd0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL post_reset: new_starts=%0d count=%0d pending=%0d, required 0/0/0",
               n_starts - starts0, o_count, exp_q.size());
    end
  endtask

  task automatic test_stray_done();
    int starts0 = n_starts;
    i_tx_done = 1'b1;
    @(negedge i_clock);
    i_tx_done = 1'b0;
    vectors++;
    if (o_busy !== 1'b0 || o_tx_start !== 1'b0) begin
      miscompares++;
      $display("FAIL stray_done: busy=%b start=%b, required 0/0", o_busy, o_tx_start);
    end
    repeat (10) @(negedge i_clock);
    vectors++;
    if (n_starts !== starts0 || o_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL stray_done_quiet: new_starts=%0d empty=%b, required 0/1", n_starts - starts0, o_empty);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_full_push_pop();
    test_timeout();
    test_async_reset();
    test_stray_done();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
